// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder/subtractor; the carry chain is cut into STAGES registered chunks.
// Define PIPE_ADDER_FLAGS_EN to build the NZCV flag pipeline; otherwise flags read 4'b0000.
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic [3:0]       flags
);

    localparam int CW = WIDTH / STAGES;

    logic              adv;
    logic [STAGES-1:0] vld_q;

    // Per-stage state: skewed operands (B already conditionally inverted),
    // deskewed partial sum, and the carry into the next chunk.
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic             c_q [STAGES];

    logic [WIDTH-1:0] a_d [STAGES];
    logic [WIDTH-1:0] b_d [STAGES];
    logic [WIDTH-1:0] s_d [STAGES];
    logic [CW:0]      t_d [STAGES];

    // A single enable for every stage keeps bubbles and ops in lockstep.
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_q[STAGES-1];
    assign sum       = s_q[STAGES-1];

    // NOTE: every variable gets a full default before any partial update, so no latch is inferred.
    always_comb begin
        a_d[0] = a;
        b_d[0] = sub ? ~b : b;
        t_d[0] = {1'b0, a_d[0][CW-1:0]} + {1'b0, b_d[0][CW-1:0]} + {{CW{1'b0}}, cin};
        s_d[0] = '0;
        s_d[0][CW-1:0] = t_d[0][CW-1:0];
        for (int k = 1; k < STAGES; k++) begin
            a_d[k] = a_q[k-1];
            b_d[k] = b_q[k-1];
            t_d[k] = {1'b0, a_q[k-1][k*CW +: CW]} + {1'b0, b_q[k-1][k*CW +: CW]}
                   + {{CW{1'b0}}, c_q[k-1]};
            s_d[k] = s_q[k-1];
            s_d[k][k*CW +: CW] = t_d[k][CW-1:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments; the pipeline arrays are
    // reset too, so a flushed pipeline shows zero sum rather than stale data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
            end
        end else if (adv) begin
            vld_q[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                vld_q[k] <= vld_q[k-1];
            end
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
                c_q[k] <= t_d[k][CW];
            end
        end
    end

`ifdef PIPE_ADDER_FLAGS_EN
    logic [3:0] flags_d;
    logic [3:0] flags_q;

    // Flags come from the last stage's combinational result so they register with the sum.
    always_comb begin
        flags_d[3] = s_d[STAGES-1][WIDTH-1];
        flags_d[2] = (s_d[STAGES-1] == '0);
        flags_d[1] = t_d[STAGES-1][CW];
        flags_d[0] = (a_d[STAGES-1][WIDTH-1] == b_d[STAGES-1][WIDTH-1])
                  && (s_d[STAGES-1][WIDTH-1] != a_d[STAGES-1][WIDTH-1]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q <= 4'b0000;
        end else if (adv) begin
            flags_q <= flags_d;
        end
    end

    assign flags = flags_q;
`else
    assign flags = 4'b0000;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed self-checking bench for pipelined_adder (WIDTH=32, STAGES=4).
// Expected flags follow whether PIPE_ADDER_FLAGS_EN is defined for the build.
module tb_pipelined_adder;

    localparam int WIDTH  = 32;
    localparam int STAGES = 4;
`ifdef PIPE_ADDER_FLAGS_EN
    localparam logic [3:0] FLAG_MASK = 4'b1111;
`else
    localparam logic [3:0] FLAG_MASK = 4'b0000;
`endif

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic [3:0]       flags;

    pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .flags    (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] s;
        logic [3:0]  f;
        int          e;
        bit          lat;
    } exp_t;

    exp_t        q[$];
    int          out_cyc[$];
    int          checks    = 0;
    int          failures  = 0;
    int          cyc       = 0;
    int          consumed  = 0;
    string       tag       = "reset";
    bit          use_hand  = 0;
    bit          lat_chk   = 1;
    logic [31:0] hand_s    = '0;
    logic [3:0]  hand_f    = '0;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", name, obs, expv);
        end
    endtask

    // Full-width reference: one wide addition, no chunking.
    function automatic logic [35:0] ref_op(input logic [31:0] x, input logic [31:0] y,
                                           input logic ci, input logic s);
        logic [31:0] yb;
        logic [32:0] t;
        logic [3:0]  f;
        yb = s ? ~y : y;
        t  = {1'b0, x} + {1'b0, yb} + 33'(ci);
        f  = {t[31], (t[31:0] == 32'd0), t[32], (x[31] == yb[31]) && (t[31] != x[31])};
        return {f & FLAG_MASK, t[31:0]};
    endfunction

    // One clock: check any consumed result, then record any accepted op.
    task automatic cycle();
        logic [35:0] r;
        exp_t        e;
        bit          acc;
        bit          con;
        #1;
        acc = in_valid && in_ready;
        con = out_valid && out_ready;
        r   = use_hand ? {hand_f & FLAG_MASK, hand_s} : ref_op(a, b, cin, sub);
        if (con) begin
            check({tag, "_pending"}, 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                check({tag, "_sum"}, sum, e.s);
                check({tag, "_flags"}, 32'(flags), 32'(e.f));
                if (e.lat) check({tag, "_latency"}, 32'(cyc - e.e + 1), 32'(STAGES));
                out_cyc.push_back(cyc);
                consumed++;
            end
        end
        @(posedge clk);
        cyc++;
        if (acc) q.push_back('{s: r[31:0], f: r[35:32], e: cyc, lat: lat_chk});
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) cycle();
        check({tag, "_drained"}, 32'(q.size()), 32'd0);
        repeat (STAGES + 1) cycle();
    endtask

    task automatic single(input string name, input logic [31:0] x, input logic [31:0] y,
                          input logic ci, input logic s, input logic [31:0] es,
                          input logic [3:0] ef);
        tag = name; use_hand = 1; hand_s = es; hand_f = ef;
        a = x; b = y; cin = ci; sub = s; in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        drain();
        use_hand = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    logic [31:0] va [8];
    logic [31:0] vb [8];
    logic        vc [8];
    logic        vs [8];
    logic [31:0] s0;
    logic [3:0]  f0;
    int          base;

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #2;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_sum", sum, 32'd0);
        check("reset_flags", 32'(flags), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        check("reset_in_ready", 32'(in_ready), 32'd1);

        // Hand-computed corner cases: full wrap, borrow, signed overflow both ways.
        single("t1_wrap",     32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0000, 4'b0110);
        single("t2_borrow",   32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 4'b1000);
        single("t3_ovf_add",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 4'b1001);
        single("t3_ovf_sub",  32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 4'b0011);

        // Back-to-back stream, checked against the reference model.
        va = '{32'h1234_5678, 32'hFFFF_FFFF, 32'h0000_00FF, 32'h0001_0000,
               32'hDEAD_BEEF, 32'h8000_0000, 32'h0000_FFFF, 32'hCAFE_BABE};
        vb = '{32'h9ABC_DEF0, 32'h0000_0000, 32'h0000_0001, 32'h0000_0001,
               32'hDEAD_BEEF, 32'h8000_0000, 32'hFFFF_0000, 32'h1357_9BDF};
        vc = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vs = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tag = "t4_stream"; out_cyc.delete(); base = consumed;
        for (int i = 0; i < 8; i++) begin
            a = va[i]; b = vb[i]; cin = vc[i]; sub = vs[i]; in_valid = 1'b1;
            cycle();
        end
        in_valid = 1'b0;
        drain();
        check("t4_count", 32'(consumed - base), 32'd8);
        check("t4_consecutive", 32'(out_cyc[out_cyc.size()-1] - out_cyc[0]), 32'd7);

        // Stall with a full pipeline; outputs must hold and nothing may be lost.
        tag = "t5_stall"; lat_chk = 0; base = consumed;
        for (int i = 0; i < 6; i++) begin
            a = 32'h0101_0101 * 32'(i + 1); b = 32'hF0F0_F0F0 ^ 32'(i);
            cin = i[0]; sub = i[1]; in_valid = 1'b1;
            if (i == 4) begin
                out_ready = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    s0 = sum; f0 = flags;
                    cycle();
                    check("t5_in_ready", 32'(in_ready), 32'd0);
                    check("t5_out_valid", 32'(out_valid), 32'd1);
                    check("t5_sum_held", sum, s0);
                    check("t5_flags_held", 32'(flags), 32'(f0));
                end
                out_ready = 1'b1;
            end
            cycle();
        end
        in_valid = 1'b0;
        drain();
        check("t5_count", 32'(consumed - base), 32'd6);
        lat_chk = 1;

        // Reset with ops in flight; only the post-reset op may emerge.
        tag = "t6_flush"; out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = 32'h8000_0000; b = 32'(i + 1); cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
            cycle();
        end
        in_valid = 1'b0;
        check("t6_pre_valid", 32'(out_valid), 32'd1);
        reset = 1'b1;
        #1;
        check("t6_async_valid", 32'(out_valid), 32'd0);
        check("t6_async_sum", sum, 32'd0);
        check("t6_async_flags", 32'(flags), 32'd0);
        q.delete();
        cycle();
        check("t6_held_valid", 32'(out_valid), 32'd0);
        reset = 1'b0; out_ready = 1'b1; base = consumed;
        tag = "t6_post";
        a = 32'h0F0F_0F0F; b = 32'h0101_0101; cin = 1'b1; sub = 1'b1; in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        drain();
        check("t6_count", 32'(consumed - base), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
